// File: rtl/prog_loader.sv
// prog_loader
// Boot-time program loader. Accepts a little-endian byte stream over a
// valid/ready handshake: 4 bytes entry point, 4 bytes word count, then
// count x 4 bytes of payload. Each payload word is written to the shared
// instruction/data memory. When the image is complete, INT is pulsed for
// one cycle with entryPoint valid, so the CPU vectors to the program.
//
// Ports:
//   clk        system clock, all state changes on posedge
//   reset      synchronous, active-high reset
//   inData     stream byte
//   inValid    inData valid this cycle
//   inReady    loader accepts a byte this cycle
//   address    memory byte address (word-aligned), valid while write is high
//   memIn      memory write data, valid while write is high
//   write      memory write strobe
//   entryPoint program entry point, valid once the entry field is complete
//   INT        one-cycle start pulse to the CPU
//   busy       load in progress (first byte accepted, START not yet reached)
//   done       image loaded and started, sticky until reset
//   error      header rejected (count too large), sticky until reset
module prog_loader #(
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter int          MAXWORDS = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  inData,
  input  logic        inValid,
  output logic        inReady,
  output logic [31:0] address,
  output logic [31:0] memIn,
  output logic        write,
  output logic [31:0] entryPoint,
  output logic        INT,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MAX_W = MAXWORDS;

  typedef enum logic [2:0] {
    HDR_E,
    HDR_N,
    DATA,
    WRITE,
    START,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      nextState;
  logic [1:0]  byteCnt;
  logic [31:0] wordIdx;
  logic [31:0] entryReg;
  logic [31:0] countReg;
  logic [31:0] wordBuf;
  logic        accept;
  logic        lastByte;
  logic [31:0] fullCount;

  // A byte transfers whenever the handshake completes; the 4th byte of any
  // field is the one that moves the FSM on.
  always_comb begin
    accept    = inValid && inReady;
    lastByte  = accept && (byteCnt == 2'd3);
    // Count as it will read once the current (4th) byte is shifted in, so
    // the header decision can be made on the same edge.
    fullCount = {inData, countReg[31:8]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HDR_E;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      HDR_E: begin
        if (lastByte) nextState = HDR_N;
      end
      HDR_N: begin
        if (lastByte) begin
          if (fullCount > MAX_W) begin
            nextState = ERR;
          end else if (fullCount == 32'd0) begin
            nextState = START;
          end else begin
            nextState = DATA;
          end
        end
      end
      DATA: begin
        if (lastByte) nextState = WRITE;
      end
      WRITE: begin
        // wordIdx still holds the index of the word being written here.
        nextState = ((wordIdx + 32'd1) == countReg) ? START : DATA;
      end
      START:   nextState = DONE;
      DONE:    nextState = DONE;
      ERR:     nextState = ERR;
      default: nextState = HDR_E;
    endcase
  end

  // Field assembly. Bytes shift in from the top so that after four bytes the
  // first one sits in bits [7:0]. The byte counter wraps naturally at four,
  // and a reset discards any partially assembled field.
  always_ff @(posedge clk) begin
    if (reset) begin
      byteCnt  <= 2'd0;
      wordIdx  <= 32'd0;
      entryReg <= 32'd0;
      countReg <= 32'd0;
      wordBuf  <= 32'd0;
    end else begin
      if (accept) begin
        byteCnt <= byteCnt + 2'd1;
        case (state)
          HDR_E:   entryReg <= {inData, entryReg[31:8]};
          HDR_N:   countReg <= {inData, countReg[31:8]};
          DATA:    wordBuf  <= {inData, wordBuf[31:8]};
          default: ;
        endcase
      end
      if (state == WRITE) begin
        wordIdx <= wordIdx + 32'd1;
      end
    end
  end

  // Outputs. address/memIn are forced to zero outside WRITE so the memory
  // bus is quiet when nothing is being written.
  always_comb begin
    inReady    = 1'b0;
    write      = 1'b0;
    address    = 32'd0;
    memIn      = 32'd0;
    entryPoint = 32'd0;
    INT        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;

    if (!reset && (state == HDR_E || state == HDR_N || state == DATA)) begin
      inReady = 1'b1;
    end

    if (state == WRITE) begin
      write   = 1'b1;
      address = BASE + (wordIdx << 2);
      memIn   = wordBuf;
    end

    // The entry register is only complete once HDR_E has been left.
    if (state != HDR_E) begin
      entryPoint = entryReg;
    end

    INT   = (state == START);
    done  = (state == DONE);
    error = (state == ERR);

    // In HDR_E a non-zero byte counter means the first byte has arrived.
    busy = (state == HDR_E && byteCnt != 2'd0) ||
           (state == HDR_N) || (state == DATA) || (state == WRITE);
  end

endmodule
